// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: 2-stage valid/ready pipe (accept -> out_valid 2 cycles later), stalls on out_ready_i, flush/squash kill.
// Build option BRU_RVC_EN: honour is_rvc_i (2-byte links) and drop the target[1] misalignment check.

package drac_pkg;
  typedef enum logic [3:0] {
    INSTR_OTHER = 4'd0,
    INSTR_JAL   = 4'd1,
    INSTR_JALR  = 4'd2,
    INSTR_BEQ   = 4'd3,
    INSTR_BNE   = 4'd4,
    INSTR_BLT   = 4'd5,
    INSTR_BGE   = 4'd6,
    INSTR_BLTU  = 4'd7,
    INSTR_BGEU  = 4'd8
  } instr_type_t;
endpackage

module branch_resolve_unit #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int ID_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  drac_pkg::instr_type_t instr_type_i,
  input  logic                  is_rvc_i,
  input  logic [PC_W-1:0]       pc_i,
  input  logic [XLEN-1:0]       rs1_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [PC_W-1:0]       pred_npc_i,
  input  logic [ID_W-1:0]       id_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ID_W-1:0]       out_id_o,
  output logic                  taken_o,
  output logic [PC_W-1:0]       result_o,
  output logic [PC_W-1:0]       link_pc_o,
  output logic                  mispredict_o,
  output logic                  misaligned_o,
  output logic [CNT_W-1:0]      mispredict_cnt_o
);

  logic [PC_W-1:0] ilen;
  logic [PC_W-1:0] link_c;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jalr_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [PC_W-1:0] tgt_c;
  logic            is_br_c;
  logic            taken_c;
  logic            op_eq;
  logic            op_lt;
  logic            op_ltu;

`ifdef BRU_RVC_EN
  assign ilen = is_rvc_i ? PC_W'(2) : PC_W'(4);
`else
  logic unused_rvc;
  assign unused_rvc = is_rvc_i;
  assign ilen       = PC_W'(4);
`endif

  assign link_c   = pc_i + ilen;
  assign br_tgt   = pc_i + PC_W'($signed(imm_i));
  assign jalr_sum = rs1_i + imm_i;
  assign jalr_tgt = PC_W'($signed(jalr_sum)) & ~PC_W'(1);

  assign op_eq  = (rs1_i == rs2_i);
  assign op_lt  = ($signed(rs1_i) < $signed(rs2_i));
  assign op_ltu = (rs1_i < rs2_i);

  always_comb begin
    is_br_c = 1'b1;
    taken_c = 1'b0;
    tgt_c   = br_tgt;
    case (instr_type_i)
      drac_pkg::INSTR_JAL:  taken_c = 1'b1;
      drac_pkg::INSTR_JALR: begin
        taken_c = 1'b1;
        tgt_c   = jalr_tgt;
      end
      drac_pkg::INSTR_BEQ:  taken_c = op_eq;
      drac_pkg::INSTR_BNE:  taken_c = !op_eq;
      drac_pkg::INSTR_BLT:  taken_c = op_lt;
      drac_pkg::INSTR_BGE:  taken_c = !op_lt;
      drac_pkg::INSTR_BLTU: taken_c = op_ltu;
      drac_pkg::INSTR_BGEU: taken_c = !op_ltu;
      default:              is_br_c = 1'b0;
    endcase
  end

  // Stage 1 state
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic            s1_is_br;
  logic            s1_taken;
  logic [PC_W-1:0] s1_tgt;
  logic [PC_W-1:0] s1_link;
  logic [PC_W-1:0] s1_pred;

  // Stage 2 state (drives the outputs)
  logic             s2_valid;
  logic [ID_W-1:0]  s2_id;
  logic             s2_taken;
  logic [PC_W-1:0]  s2_result;
  logic [PC_W-1:0]  s2_link;
  logic             s2_mis;
  logic             s2_mal;
  logic [CNT_W-1:0] mis_cnt;

  logic [PC_W-1:0] result_c;
  logic            mal_c;
  logic            mis_c;
  logic            s1_advance;
  logic            squash;
  logic            accept;
  logic            s2_load;

  assign result_c = s1_taken ? s1_tgt : s1_link;
`ifdef BRU_RVC_EN
  assign mal_c = 1'b0;
`else
  assign mal_c = s1_taken && s1_tgt[1];
`endif
  assign mis_c = s1_is_br && !mal_c && (result_c != s1_pred);

  assign s1_advance = !s2_valid || out_ready_i;
  assign squash     = out_valid_o && out_ready_i && mispredict_o;
  assign in_ready_o = !flush_i && !squash && (!s1_valid || s1_advance);
  assign accept     = in_valid_i && in_ready_o;
  // A squash kills the younger S1 entry instead of promoting it.
  assign s2_load    = !flush_i && s1_advance && s1_valid && !squash;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_is_br  <= 1'b0;
      s1_taken  <= 1'b0;
      s1_tgt    <= '0;
      s1_link   <= '0;
      s1_pred   <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_taken  <= 1'b0;
      s2_result <= '0;
      s2_link   <= '0;
      s2_mis    <= 1'b0;
      s2_mal    <= 1'b0;
      mis_cnt   <= '0;
    end else begin
      if (flush_i) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (accept) begin
          s1_valid <= 1'b1;
        end else if (s1_advance) begin
          s1_valid <= 1'b0;
        end
        if (s1_advance) begin
          s2_valid <= s1_valid && !squash;
        end
        if (squash && (mis_cnt != {CNT_W{1'b1}})) begin
          mis_cnt <= mis_cnt + CNT_W'(1);
        end
      end
      if (accept) begin
        s1_id    <= id_i;
        s1_is_br <= is_br_c;
        s1_taken <= taken_c;
        s1_tgt   <= tgt_c;
        s1_link  <= link_c;
        s1_pred  <= pred_npc_i;
      end
      if (s2_load) begin
        s2_id     <= s1_id;
        s2_taken  <= s1_taken;
        s2_result <= result_c;
        s2_link   <= s1_link;
        s2_mis    <= mis_c;
        s2_mal    <= mal_c;
      end
    end
  end

  assign out_valid_o      = s2_valid;
  assign out_id_o         = s2_id;
  assign taken_o          = s2_taken;
  assign result_o         = s2_result;
  assign link_pc_o        = s2_link;
  assign mispredict_o     = s2_valid && s2_mis;
  assign misaligned_o     = s2_valid && s2_mal;
  assign mispredict_cnt_o = mis_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-built corner sequences and random traffic vs a queue model.
module tb_branch_resolve_unit;
  import drac_pkg::*;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        is_rvc = 1'b0;
  instr_type_t instr_type = INSTR_OTHER;
  logic [63:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0, pred = '0;
  logic [5:0]  id = '0;

  logic             in_ready_o, out_valid_o, taken_o, mispredict_o, misaligned_o;
  logic [5:0]       out_id_o;
  logic [63:0]      result_o, link_pc_o;
  logic [CNT_W-1:0] mispredict_cnt_o;

  branch_resolve_unit #(.XLEN(64), .PC_W(64), .ID_W(6), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .instr_type_i(instr_type), .is_rvc_i(is_rvc), .pc_i(pc),
    .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .pred_npc_i(pred), .id_i(id),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_id_o(out_id_o),
    .taken_o(taken_o), .result_o(result_o), .link_pc_o(link_pc_o),
    .mispredict_o(mispredict_o), .misaligned_o(misaligned_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    instr_type_t typ; logic rvc;
    logic [63:0] pc, rs1, rs2, imm, pred; logic [5:0] id;
  } req_t;

  typedef struct {
    logic [5:0] id; logic taken; logic [63:0] result, link; logic mis, mal; int acc;
  } rsp_t;

  typedef struct {
    instr_type_t typ; logic rvc; logic [63:0] pc, rs1, rs2, imm, pred;
    logic taken; logic [63:0] result, link; logic mis, mal;
  } vec_t;

  int   checks = 0, failures = 0, cyc = 0, cnt_exp = 0, acc_cnt = 0;
  rsp_t q[$];
  rsp_t cur_exp;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference built straight from the instruction semantics.
  function automatic rsp_t ref_model(req_t r);
    rsp_t e; logic [63:0] tgt; logic is_br; logic [63:0] ilen;
    ilen = 64'd4;
`ifdef BRU_RVC_EN
    if (r.rvc) ilen = 64'd2;
`endif
    e.id = r.id; e.acc = 0; e.link = r.pc + ilen;
    e.taken = 1'b0; is_br = 1'b1; tgt = r.pc + r.imm;
    case (r.typ)
      INSTR_JAL:  e.taken = 1'b1;
      INSTR_JALR: begin e.taken = 1'b1; tgt = (r.rs1 + r.imm) & ~64'd1; end
      INSTR_BEQ:  e.taken = (r.rs1 == r.rs2);
      INSTR_BNE:  e.taken = (r.rs1 != r.rs2);
      INSTR_BLT:  e.taken = ($signed(r.rs1) < $signed(r.rs2));
      INSTR_BGE:  e.taken = ($signed(r.rs1) >= $signed(r.rs2));
      INSTR_BLTU: e.taken = (r.rs1 < r.rs2);
      INSTR_BGEU: e.taken = (r.rs1 >= r.rs2);
      default:    is_br = 1'b0;
    endcase
    e.result = e.taken ? tgt : e.link;
    e.mal = 1'b0;
`ifndef BRU_RVC_EN
    e.mal = e.taken && tgt[1];
`endif
    e.mis = is_br && !e.mal && (e.result != r.pred);
    return e;
  endfunction

  function automatic req_t mk(instr_type_t t, logic [63:0] p, logic [63:0] a, logic [63:0] b,
                              logic [63:0] i, logic [63:0] pr, int rid);
    req_t r;
    r.typ = t; r.rvc = 1'b0; r.pc = p; r.rs1 = a; r.rs2 = b; r.imm = i; r.pred = pr; r.id = 6'(rid);
    return r;
  endfunction

  task automatic drive(input req_t r, input rsp_t e);
    instr_type = r.typ; is_rvc = r.rvc; pc = r.pc; rs1 = r.rs1; rs2 = r.rs2;
    imm = r.imm; pred = r.pred; id = r.id;
    cur_exp = e; cur_exp.id = r.id;
    in_valid = 1'b1;
  endtask

  // One clock: check against the model at negedge, update the model, advance.
  task automatic tick();
    logic exp_ov, exp_ir, sq; rsp_t tmp;
    @(negedge clk);
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    sq     = exp_ov && out_ready && q[0].mis;
    exp_ir = !flush && !sq && ((q.size() < 2) || out_ready);
    check("out_valid", 64'(out_valid_o), 64'(exp_ov));
    check("in_ready", 64'(in_ready_o), 64'(exp_ir));
    check("mispredict_cnt", 64'(mispredict_cnt_o), 64'(cnt_exp));
    if (exp_ov) begin
      check("out_id", 64'(out_id_o), 64'(q[0].id));
      check("taken", 64'(taken_o), 64'(q[0].taken));
      check("result", result_o, q[0].result);
      check("link_pc", link_pc_o, q[0].link);
      check("mispredict", 64'(mispredict_o), 64'(q[0].mis));
      check("misaligned", 64'(misaligned_o), 64'(q[0].mal));
    end
    if (flush) begin
      q.delete();
    end else begin
      if (exp_ov && out_ready) begin
        tmp = q.pop_front();
        if (sq) begin
          q.delete();
          if (cnt_exp < CNT_MAX) cnt_exp++;
        end
      end
      if (in_valid && exp_ir) begin
        tmp = cur_exp; tmp.acc = cyc;
        q.push_back(tmp);
        acc_cnt++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    tick();
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d entries outstanding, required 0", q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); cnt_exp = 0; cyc++;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_taken", 64'(taken_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_link", link_pc_o, 64'd0);
    check("rst_id", 64'(out_id_o), 64'd0);
    check("rst_mispredict", 64'(mispredict_o), 64'd0);
    check("rst_misaligned", 64'(misaligned_o), 64'd0);
    check("rst_cnt", 64'(mispredict_cnt_o), 64'd0);
  endtask

  function automatic req_t rand_req(int rid);
    req_t r; logic [11:0] b; int sel;
    r.typ = instr_type_t'(4'($urandom_range(0, 8)));
    r.rvc = 1'($urandom_range(0, 1));
    r.pc  = {$urandom(), $urandom()} & ~64'd1;
    r.rs1 = ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 8)) - 64'd4;
    sel   = $urandom_range(0, 2);
    r.rs2 = (sel == 0) ? r.rs1 : (sel == 1) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 8)) - 64'd4;
    b     = 12'($urandom());
    r.imm = {{52{b[11]}}, b};
    r.id  = 6'(rid);
    r.pred = '0;
    case ($urandom_range(0, 2))
      0:       r.pred = ref_model(r).result;
      1:       r.pred = r.pc + 64'd4;
      default: r.pred = {$urandom(), $urandom()};
    endcase
    return r;
  endfunction

  initial begin
    req_t r; rsp_t e; int base;
    // {type, rvc, pc, rs1, rs2, imm, pred, taken, result, link, mispredict, misaligned}
    vecs[0] = '{INSTR_BEQ, 1'b0, 64'h1000, 64'd5, 64'd5, 64'h40, 64'h1004, 1'b1, 64'h1040, 64'h1004, 1'b1, 1'b0};
    vecs[1] = '{INSTR_BLT, 1'b0, 64'h2000, '1, 64'd1, 64'h80, 64'h2004, 1'b1, 64'h2080, 64'h2004, 1'b1, 1'b0};
    vecs[2] = '{INSTR_BLTU, 1'b0, 64'h2000, '1, 64'd1, 64'h80, 64'h2004, 1'b0, 64'h2004, 64'h2004, 1'b0, 1'b0};
`ifdef BRU_RVC_EN
    vecs[3] = '{INSTR_JALR, 1'b0, 64'h3000, 64'h2003, 64'd0, 64'd0, 64'h3004, 1'b1, 64'h2002, 64'h3004, 1'b1, 1'b0};
    vecs[9] = '{INSTR_JAL, 1'b1, 64'h7000, 64'd0, 64'd0, 64'h6, 64'h7006, 1'b1, 64'h7006, 64'h7002, 1'b0, 1'b0};
`else
    vecs[3] = '{INSTR_JALR, 1'b0, 64'h3000, 64'h2003, 64'd0, 64'd0, 64'h3004, 1'b1, 64'h2002, 64'h3004, 1'b0, 1'b1};
    vecs[9] = '{INSTR_JAL, 1'b1, 64'h7000, 64'd0, 64'd0, 64'h6, 64'h7006, 1'b1, 64'h7006, 64'h7004, 1'b0, 1'b1};
`endif
    vecs[4] = '{INSTR_BNE, 1'b0, 64'h100, 64'd7, 64'd7, 64'h20, 64'h104, 1'b0, 64'h104, 64'h104, 1'b0, 1'b0};
    vecs[5] = '{INSTR_BGE, 1'b0, 64'h400, 64'd1, '1, -64'sd8, 64'h3F8, 1'b1, 64'h3F8, 64'h404, 1'b0, 1'b0};
    vecs[6] = '{INSTR_BGEU, 1'b0, 64'h400, 64'd1, '1, -64'sd8, 64'h404, 1'b0, 64'h404, 64'h404, 1'b0, 1'b0};
    vecs[7] = '{INSTR_JAL, 1'b0, 64'h5000, 64'd0, 64'd0, 64'h100, 64'h5100, 1'b1, 64'h5100, 64'h5004, 1'b0, 1'b0};
    vecs[8] = '{INSTR_OTHER, 1'b0, 64'h6000, 64'd3, 64'd3, 64'h10, 64'h1234, 1'b0, 64'h6004, 64'h6004, 1'b0, 1'b0};
    vecs[10] = '{INSTR_JAL, 1'b0, 64'h10, 64'd0, 64'd0, -64'sd32, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF0, 64'h14, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      r = mk(vecs[i].typ, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pred, i + 1);
      r.rvc = vecs[i].rvc;
      e.taken = vecs[i].taken; e.result = vecs[i].result; e.link = vecs[i].link;
      e.mis = vecs[i].mis; e.mal = vecs[i].mal; e.acc = 0; e.id = r.id;
      out_ready = 1'b1;
      drive(r, e);
      tick();
      drain();
    end

    // Back-to-back stream of 4 with a 3-cycle consumer stall.
    do_reset();
    base = acc_cnt;
    for (int t = 0; t < 16; t++) begin
      out_ready = !(t >= 3 && t < 6);
      if (acc_cnt - base < 4) begin
        r = mk(INSTR_BNE, 64'h100 * (acc_cnt - base + 1), 64'd7, 64'd7, 64'h40,
               64'h100 * (acc_cnt - base + 1) + 64'd4, 20 + acc_cnt - base);
        drive(r, ref_model(r));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    drain();

    // Mispredict squashes the younger entry; the same-cycle input waits.
    do_reset();
    out_ready = 1'b1;
    r = mk(INSTR_BEQ, 64'h1000, 64'd5, 64'd5, 64'h40, 64'h1004, 30);
    drive(r, ref_model(r)); tick();
    r = mk(INSTR_JAL, 64'h2000, 64'd0, 64'd0, 64'h10, 64'h2010, 31);
    drive(r, ref_model(r)); tick();
    r = mk(INSTR_JAL, 64'h3000, 64'd0, 64'd0, 64'h20, 64'h3020, 32);
    drive(r, ref_model(r));
    base = acc_cnt;
    for (int k = 0; k < 6 && acc_cnt == base; k++) tick();
    drain();

    // Flush with both stages occupied.
    out_ready = 1'b0;
    r = mk(INSTR_JAL, 64'h4000, 64'd0, 64'd0, 64'h8, 64'h4008, 40);
    drive(r, ref_model(r)); tick();
    r = mk(INSTR_JAL, 64'h4100, 64'd0, 64'd0, 64'h8, 64'h4108, 41);
    drive(r, ref_model(r)); tick();
    tick();
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; tick();
    out_ready = 1'b1;
    r = mk(INSTR_JAL, 64'h4200, 64'd0, 64'd0, 64'h8, 64'h4208, 42);
    drive(r, ref_model(r)); tick();
    drain();

    // Counter saturation with a 2-bit counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      r = mk(INSTR_BEQ, 64'h1000, 64'd5, 64'd5, 64'h40, 64'h1004, 50 + k);
      drive(r, ref_model(r)); tick();
      drain();
    end
    check("cnt_saturated", 64'(mispredict_cnt_o), 64'd3);

    // Reset while entries are in flight.
    out_ready = 1'b0;
    r = mk(INSTR_BLT, 64'h8000, '1, 64'd1, 64'h40, 64'h8004, 60);
    drive(r, ref_model(r)); tick();
    r = mk(INSTR_JAL, 64'h9000, 64'd0, 64'd0, 64'h42, 64'h9004, 61);
    drive(r, ref_model(r)); tick(); tick();
    do_reset();

    // Random traffic with stalls and occasional flushes.
    for (int t = 0; t < 3000; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) != 0) begin
        r = rand_req(t);
        drive(r, ref_model(r));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
